// File: rtl/db9md_pad_reader.sv
// Polls one or two Mega Drive 3/6-button pads on the SNAC DB9 port, with the two players multiplexed by joy_split.
// Each player word is assembled from per-phase shadow samples and committed in a single clock.
module db9md_pad_reader #(
   parameter int PHASE_CYCLES = 400,
   parameter int IDLE_CYCLES  = 80000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [5:0]  joy_in,
   output logic        joy_mdsel,
   output logic        joy_split,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic [1:0]  pad_present,
   output logic [1:0]  six_button,
   output logic        scan_done,
   output logic [1:0]  dbg_state
);

   localparam int MAX_CNT = (IDLE_CYCLES > PHASE_CYCLES) ? IDLE_CYCLES : PHASE_CYCLES;
   localparam int CW      = $clog2(MAX_CNT);
   localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_CYCLES - 1);
   localparam logic [CW-1:0] PHASE_LAST = CW'(PHASE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SCAN   = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    phase_q, phase_d;
   logic          split_q, split_d;
   logic          mdsel_q, mdsel_d;
   logic          sample, commit;

   logic [5:0]    sync1_q, sync2_q;
   logic [5:0]    pins;
   logic [5:0]    p0_q;
   logic [2:0]    p1_q;
   logic          six_q;
   logic [3:0]    p6_q;
   logic [15:0]   word_raw, word;

   logic [15:0]   joy1_q, joy2_q;
   logic [1:0]    present_q, six_btn_q;
   logic          done_q;

   assign pins = ~sync2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      split_d = split_q;
      sample  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cnt_q == IDLE_LAST) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
               split_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_SETTLE: begin
            if (cnt_q == PHASE_LAST) begin
               state_d = ST_SCAN;
               cnt_d   = '0;
               phase_d = 3'd0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_SCAN: begin
            if (cnt_q == PHASE_LAST) begin
               sample = 1'b1;
               cnt_d  = '0;
               if (phase_q == 3'd7) state_d = ST_COMMIT;
               else                 phase_d = phase_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            commit = 1'b1;
            cnt_d  = '0;
            if (!split_q) begin
               split_d = 1'b1;
               state_d = ST_SETTLE;
            end else begin
               split_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
      endcase
      // Registered from next state so SELECT edges line up exactly with phase boundaries.
      mdsel_d = !(state_d == ST_SCAN && phase_d[0]);
   end

   always_comb begin
      word_raw = {4'b0000, p6_q[0], p6_q[1], p6_q[2], p6_q[3],
                  p1_q[2], p1_q[1], p0_q[5], p0_q[4],
                  p0_q[0], p0_q[1], p0_q[2], p0_q[3]};
      word = 16'h0000;
      if (p1_q[0]) begin
         word = word_raw;
         if (!six_q) word[11:8] = 4'b0000;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         phase_q   <= 3'd0;
         split_q   <= 1'b0;
         mdsel_q   <= 1'b1;
         sync1_q   <= 6'h3F;
         sync2_q   <= 6'h3F;
         p0_q      <= 6'h00;
         p1_q      <= 3'b000;
         six_q     <= 1'b0;
         p6_q      <= 4'h0;
         joy1_q    <= 16'h0000;
         joy2_q    <= 16'h0000;
         present_q <= 2'b00;
         six_btn_q <= 2'b00;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         split_q <= split_d;
         mdsel_q <= mdsel_d;
         sync1_q <= joy_in;
         sync2_q <= sync1_q;
         done_q  <= commit & split_q;
         if (sample) begin
            case (phase_q)
               3'd0: p0_q  <= pins;
               3'd1: p1_q  <= {pins[5], pins[4], pins[2] & pins[3]};
               3'd5: six_q <= p1_q[0] & (&pins[3:0]);
               3'd6: p6_q  <= pins[3:0];
               default: ;
            endcase
         end
         if (commit && !split_q) begin
            joy1_q       <= word;
            present_q[0] <= p1_q[0];
            six_btn_q[0] <= p1_q[0] & six_q;
         end
         if (commit && split_q) begin
            joy2_q       <= word;
            present_q[1] <= p1_q[0];
            six_btn_q[1] <= p1_q[0] & six_q;
         end
      end
   end

   assign joy_mdsel   = mdsel_q;
   assign joy_split   = split_q;
   assign joystick1   = joy1_q;
   assign joystick2   = joy2_q;
   assign pad_present = present_q;
   assign six_button  = six_btn_q;
   assign scan_done   = done_q;
   assign dbg_state   = state_q;

endmodule

// File: doc/db9md_pad_reader.md
Name: db9md_pad_reader

Overview:
- Polls one or two Sega Mega Drive 3/6-button pads through the SNAC DB9 user port, time-multiplexed by an external split switch.
- Produces two debounced-by-frame, active-high joystick words in the same bit layout the arcade top level already consumes for its DB9MD path.
- Sits directly upstream of the top-level input mapping, which ORs these words with USB joysticks.
- Runs on clk_sys (40 MHz).

Parameters:
- PHASE_CYCLES, 400, clocks per select half-phase (10 us at 40 MHz); must be ≥4.
- IDLE_CYCLES, 80000, clocks between completed two-player scans (2 ms; ≥1.6 ms required for the 6-button pad counter to reset).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- joy_in  in  6  raw pad pins, active-low: [0]=Up, [1]=Down, [2]=Left, [3]=Right, [4]=B/A, [5]=C/Start.
- joy_mdsel  out  1  pad SELECT line.
- joy_split  out  1  port multiplexer select: 0=player 1, 1=player 2.
- joystick1  out  16  player 1 buttons, active-high.
- joystick2  out  16  player 2 buttons, active-high.
- pad_present  out  2  [0]=P1, [1]=P2 pad detected.
- six_button  out  2  [0]=P1, [1]=P2 is a 6-button pad.
- scan_done  out  1  one-clock strobe after both players are updated.

Behaviour:
- Output bit map for joystick1/2:
  - [0]=R, [1]=L, [2]=D, [3]=U, [4]=B, [5]=C, [6]=A, [7]=Start.
  - [8]=Mode, [9]=X, [10]=Y, [11]=Z.
  - [15:12]=0 always.
- Reset values (asynchronous, while reset_n=0):
  - joy_mdsel=1, joy_split=0.
  - joystick1=joystick2=0, pad_present=0, six_button=0, scan_done=0.
  - FSM in IDLE with the counter cleared.
- Input sync: joy_in passes through a 2-flop synchronizer (reset value 6'h3F) and is then inverted. All decoding uses the synchronized value.
- FSM states:
  - IDLE: count IDLE_CYCLES, then go to SETTLE with joy_split=0.
  - SETTLE: hold mdsel=1 for PHASE_CYCLES (split mux settling), then go to SCAN with phase=0.
  - SCAN: phases 0..7. mdsel = 1 on even phases, 0 on odd phases. Each phase lasts PHASE_CYCLES.
    - Sample on the last clock of each phase, before mdsel toggles, into a per-phase shadow register.
    - After phase 7, one clock of mdsel=1 is driven.
    - If split was 0: commit P1, set split=1, go to SETTLE.
    - If split was 1: commit P2, set split=0, pulse scan_done, go to IDLE.
- Decode (active-high, after inversion):
  - Phase 0 (sel=1): U, D, L, R, B, C.
  - Phase 1 (sel=0): A and Start from pins [4], [5]. present = L and R both asserted (pins 2 and 3 read low).
  - Phase 5 (sel=0): six = present AND U, D, L, R all asserted.
  - Phase 6 (sel=1): pin 0=Z, 1=Y, 2=X, 3=Mode.
- Commit:
  - If !present: the player word = 0 and its present/six bits = 0.
  - Else if !six: bits [11:8] = 0.
  - Else: full word.
  - The whole word updates in a single clock; no partial updates are ever visible.
- joy_split changes only when mdsel=1 and the FSM is not in SCAN.
- Reset mid-scan: all outputs return to their reset values immediately; no partial commit. After release, scanning starts from IDLE.
- Pad unplugged mid-scan: the word for that player clears at its next commit.

Test Plan:
- 6-button model on P1, Right+A+Z held, no P2 pad. After one scan: joystick1=16'h0841, joystick2=0, pad_present=2'b01, six_button=2'b01, one scan_done pulse.
- 3-button model on both ports, P1 Start+Up, P2 B+C. Expected: joystick1=16'h0088, joystick2=16'h0030, six_button=0, pad_present=2'b11.
- Timing with PHASE_CYCLES=8, IDLE_CYCLES=100:
  - Each mdsel half-period is exactly 8 clocks.
  - Split toggles only while mdsel=1.
  - scan_done recurs every 100+2*(8+64+1) clocks (100 idle + 2 × (8 settle + 64 scan + 1 commit)).
- All pins high (no pads): both words stay 0, pad_present=0, scan_done still pulses every scan.
- Assert reset_n=0 during P2 phase 4 with nonzero prior outputs: all outputs read reset values on the same edge. After release, the first scan_done occurs after a full IDLE+scan sequence, with fresh data.
- Change P1 buttons mid-scan between phase 0 and phase 6 sampling: the committed word reflects the per-phase samples, and joystick1 changes in exactly one clock.
